// File: rtl/dmem_arbiter.sv
// Two-port arbiter sharing one combinational-read DATAMEM between the CPU data port (0)
// and a loader/debug master (1). Define DMEM_ARB_RR_EN for round-robin ties; default is fixed priority to port 0.
module dmem_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int MEM_LAT = 2
) (
    input  logic          Clk,
    input  logic          Clr,

    input  logic          req0,
    input  logic          we0,
    input  logic [AW-1:0] addr0,
    input  logic [DW-1:0] wdata0,
    output logic          ack0,
    output logic [DW-1:0] rdata0,

    input  logic          req1,
    input  logic          we1,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata1,
    output logic          ack1,
    output logic [DW-1:0] rdata1,

    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_we,
    input  logic [DW-1:0] mem_rdata,

    output logic          busy
);

    // state  | meaning
    // IDLE   | no access in flight; arbitration happens here
    // ACCESS | memory bus held for MEM_LAT cycles, write strobe in the last one
    // RESP   | one-cycle ack to the winner, then back to IDLE

    localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [CW-1:0] LAT_INIT = CW'(MEM_LAT - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nxt;

    logic          win;
    logic          lat_we;
    logic          last_grant;
    logic [CW-1:0] lat_cnt;

    logic          req_any;
    logic          grant_id;
    logic          final_cyc;

    assign req_any   = req0 | req1;
    assign final_cyc = (lat_cnt == '0);

`ifdef DMEM_ARB_RR_EN
    always_comb begin
        grant_id = 1'b0;
        if (req0 && req1) begin
            grant_id = ~last_grant;
        end else begin
            grant_id = req1;
        end
    end
`else
    // last_grant is kept up to date so both builds share the same state, but only round-robin reads it
    logic unused_last_grant;
    assign unused_last_grant = last_grant;

    always_comb begin
        grant_id = 1'b0;
        if (!req0) begin
            grant_id = 1'b1;
        end
    end
`endif

    always_ff @(posedge Clk) begin
        if (Clr) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (req_any) begin
                    state_nxt = ACCESS;
                end
            end
            ACCESS: begin
                if (final_cyc) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // mem_addr/mem_wdata double as the latched request, so they hold outside ACCESS
    always_ff @(posedge Clk) begin
        if (Clr) begin
            win        <= 1'b0;
            lat_we     <= 1'b0;
            lat_cnt    <= '0;
            last_grant <= 1'b1;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            rdata0     <= '0;
            rdata1     <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (req_any) begin
                        win     <= grant_id;
                        lat_cnt <= LAT_INIT;
                        if (grant_id) begin
                            lat_we    <= we1;
                            mem_addr  <= addr1;
                            mem_wdata <= wdata1;
                        end else begin
                            lat_we    <= we0;
                            mem_addr  <= addr0;
                            mem_wdata <= wdata0;
                        end
                    end
                end
                ACCESS: begin
                    if (!final_cyc) begin
                        lat_cnt <= lat_cnt - 1'b1;
                    end else if (!lat_we) begin
                        if (win) begin
                            rdata1 <= mem_rdata;
                        end else begin
                            rdata0 <= mem_rdata;
                        end
                    end
                end
                RESP: begin
                    last_grant <= win;
                end
                default: begin
                    lat_cnt <= '0;
                end
            endcase
        end
    end

    always_comb begin
        mem_we = 1'b0;
        ack0   = 1'b0;
        ack1   = 1'b0;
        busy   = 1'b0;
        unique case (state)
            IDLE: begin
                busy = 1'b0;
            end
            ACCESS: begin
                busy   = 1'b1;
                mem_we = lat_we & final_cyc;
            end
            RESP: begin
                busy = 1'b1;
                ack0 = ~win;
                ack1 = win;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

endmodule
